// File: rtl/alu_op_driver.sv
// alu_op_driver: registers commands onto the ALU inputs, samples the result after SETTLE cycles and returns it tagged
module alu_op_driver #(
  parameter int TAG_W = 4,
  parameter int SETTLE = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [4:0]       cmd_op,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [4:0]       alu_ctrl,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             sticky_clr,
  output logic [1:0]       sticky_flags,
  output logic [CNT_W-1:0] op_count
);
  localparam logic [1:0] IDLE = 2'd0, DRIVE = 2'd1, RESP = 2'd2;
  logic [1:0] state;
  logic [3:0] cnt;
  logic [TAG_W-1:0] tag_q;
  logic cap;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign cap = state == DRIVE && cnt == 4'd0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      tag_q <= '0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= '0;
      rsp_result <= '0;
      rsp_flags <= '0;
      rsp_tag <= '0;
      sticky_flags <= '0;
      op_count <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          alu_a <= cmd_a;
          alu_b <= cmd_b;
          alu_ctrl <= cmd_op;
          tag_q <= cmd_tag;
          cnt <= 4'(SETTLE - 1);
          state <= DRIVE;
        end
        DRIVE: if (cnt == 4'd0) begin
          rsp_result <= alu_result;
          rsp_flags <= {alu_negative, alu_overflow, alu_carry, alu_zero};
          rsp_tag <= tag_q;
          state <= RESP;
        end else cnt <= cnt - 4'd1;
        RESP: if (rsp_ready) begin
          op_count <= op_count + CNT_W'(1);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // clear applies before the capture sets, so a same-cycle clear keeps only the new bits
      sticky_flags <= (sticky_clr ? 2'b00 : sticky_flags) | (cap ? {alu_overflow, alu_carry} : 2'b00);
    end
  end
endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver: randomized and directed checks of alu_op_driver against a cycle-timestamp reference model
module tb_alu_op_driver;
  localparam int TAG_W = 4, SETTLE = 3, CNT_W = 4;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, rsp_valid, rsp_ready = 1, sticky_clr = 0;
  logic [4:0] cmd_op = 0, alu_ctrl;
  logic [31:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_result, rsp_result;
  logic [TAG_W-1:0] cmd_tag = 0, rsp_tag;
  logic alu_zero, alu_carry, alu_overflow, alu_negative;
  logic [3:0] rsp_flags;
  logic [1:0] sticky_flags;
  logic [CNT_W-1:0] op_count;
  int checks = 0, errors = 0;
  bit started = 0;

  alu_op_driver #(.TAG_W(TAG_W), .SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_negative(alu_negative), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .sticky_clr(sticky_clr), .sticky_flags(sticky_flags), .op_count(op_count));

  always #5 clk = ~clk;

  // Stand-in ALU: returns {N,V,C,Z,result}; ops 5/6 add, others scramble the operands
  function automatic logic [35:0] alu_f(logic [4:0] op, logic [31:0] a, logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = {1'b0, a} + {1'b0, b};
    if (op == 5'd5 || op == 5'd6) begin
      r = s[31:0];
      c = s[32];
      v = (a[31] == b[31]) && (r[31] != a[31]);
    end else begin
      r = a ^ {b[15:0], b[31:16]} ^ {27'b0, op};
      c = r[3];
      v = r[7];
    end
    return {r[31], v, c, r == 32'd0, r};
  endfunction

  logic [35:0] alu_out;
  assign alu_out = alu_f(alu_ctrl, alu_a, alu_b);
  assign {alu_negative, alu_overflow, alu_carry, alu_zero, alu_result} = alu_out;

  // Reference model: an op accepted in cycle acc is captured at the end of cycle acc+SETTLE
  int cyc = 0, acc = 0;
  bit pend = 0;
  logic [35:0] pe = 0;
  logic [TAG_W-1:0] pt = 0, m_rt = 0;
  logic [31:0] m_a = 0, m_b = 0, m_rr = 0;
  logic [4:0] m_op = 0;
  logic [3:0] m_rf = 0;
  logic [1:0] m_st = 0;
  logic [CNT_W-1:0] m_cnt = 0;
  wire capt = pend && cyc == acc + SETTLE;
  wire vnow = pend && cyc > acc + SETTLE;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pend <= 0; m_a <= 0; m_b <= 0; m_op <= 0; m_rr <= 0; m_rf <= 0; m_rt <= 0; m_st <= 0; m_cnt <= 0;
    end else begin
      if (!pend && cmd_valid) begin
        pend <= 1; acc <= cyc; m_a <= cmd_a; m_b <= cmd_b; m_op <= cmd_op;
        pe <= alu_f(cmd_op, cmd_a, cmd_b); pt <= cmd_tag;
      end
      if (capt) begin
        m_rr <= pe[31:0]; m_rf <= pe[35:32]; m_rt <= pt;
      end
      m_st <= (sticky_clr ? 2'b00 : m_st) | (capt ? pe[34:33] : 2'b00);
      if (vnow && rsp_ready) begin
        pend <= 0; m_cnt <= m_cnt + 1'b1;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) if (started) begin
    chk("cmd_ready", 64'(cmd_ready), 64'(!pend));
    chk("rsp_valid", 64'(rsp_valid), 64'(vnow));
    chk("alu_a", 64'(alu_a), 64'(m_a));
    chk("alu_b", 64'(alu_b), 64'(m_b));
    chk("alu_ctrl", 64'(alu_ctrl), 64'(m_op));
    chk("rsp_result", 64'(rsp_result), 64'(m_rr));
    chk("rsp_flags", 64'(rsp_flags), 64'(m_rf));
    chk("rsp_tag", 64'(rsp_tag), 64'(m_rt));
    chk("sticky_flags", 64'(sticky_flags), 64'(m_st));
    chk("op_count", 64'(op_count), 64'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    int n = 0;
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = t; cmd_valid = 1;
    while (!cmd_ready && n < 40) begin step(); n++; end
    chk("accept_timeout", 64'(cmd_ready), 64'(1));
    step();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 40) begin step(); n++; end
    chk("rsp_timeout", 64'(rsp_valid), 64'(1));
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  initial begin
    int n;
    logic [31:0] r0;
    logic [CNT_W-1:0] c0;
    do_reset();
    started = 1;
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("reset_op_count", 64'(op_count), 64'(0));
    // T1: unsigned add wrapping to zero, latency from accept
    send(5'b00101, 32'hFFFF_FFFF, 32'd1, 4'd3);
    wait_rsp(n);
    chk("t1_latency", 64'(n), 64'(SETTLE));
    chk("t1_result", 64'(rsp_result), 64'h0);
    chk("t1_flags", 64'(rsp_flags), 64'(4'b0011));
    chk("t1_tag", 64'(rsp_tag), 64'(3));
    chk("t1_sticky", 64'(sticky_flags), 64'(2'b01));
    step();
    // T2/T4: signed overflow, sticky cleared in the capture cycle
    send(5'b00110, 32'h7FFF_FFFF, 32'd1, 4'd5);
    repeat (SETTLE - 1) step();
    sticky_clr = 1;
    step();
    sticky_clr = 0;
    chk("t2_valid", 64'(rsp_valid), 64'(1));
    chk("t2_result", 64'(rsp_result), 64'h8000_0000);
    chk("t2_flags", 64'(rsp_flags), 64'(4'b1100));
    chk("t4_sticky", 64'(sticky_flags), 64'(2'b10));
    step();
    // T3: backpressure with a competing command
    rsp_ready = 0;
    send(5'd9, 32'h1234_5678, 32'h0BAD_F00D, 4'd7);
    wait_rsp(n);
    r0 = rsp_result; c0 = op_count;
    cmd_valid = 1; cmd_a = 32'hDEAD_BEEF; cmd_tag = 4'd1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_held_valid", 64'(rsp_valid), 64'(1));
      chk("t3_busy", 64'(cmd_ready), 64'(0));
      chk("t3_held_result", 64'(rsp_result), 64'(r0));
    end
    cmd_valid = 0; rsp_ready = 1;
    step();
    chk("t3_count", 64'(op_count), 64'(c0 + 1'b1));
    // T5: reset in the middle of DRIVE
    send(5'd6, 32'd10, 32'd20, 4'd9);
    step();
    rst = 1; step(); rst = 0;
    chk("t5_valid", 64'(rsp_valid), 64'(0));
    chk("t5_ready", 64'(cmd_ready), 64'(1));
    chk("t5_alu_a", 64'(alu_a), 64'(0));
    chk("t5_count", 64'(op_count), 64'(0));
    repeat (6) step();
    send(5'd5, 32'd40, 32'd2, 4'd2);
    wait_rsp(n);
    chk("t5_after_result", 64'(rsp_result), 64'd42);
    step();
    // T6: wrap of a 4-bit counter with ordered tags
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send(5'(i), $urandom, $urandom, 4'(i));
      wait_rsp(n);
      chk("t6_tag", 64'(rsp_tag), 64'(i));
      step();
    end
    chk("t6_wrap", 64'(op_count), 64'(0));
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_op = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'($urandom_range(5, 6));
      cmd_a = $urandom; cmd_b = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
      cmd_tag = 4'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      sticky_clr = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 199) == 0;
      step();
    end
    rst = 0; cmd_valid = 0; sticky_clr = 0; rsp_ready = 1;
    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
